// File: rtl/computation_layer_loader.sv
// Double-buffered serial-to-parallel loader feeding a computation layer.
// Fills one bank from a valid/ready stream while the other bank is held stable for the layer.
`ifndef F_NBITS
`define F_NBITS 64
`endif

module computation_layer_loader #(
  parameter int unsigned ninputs  = 8,
  parameter int unsigned nmuxsels = 1,
  parameter int unsigned nidxbits = $clog2(ninputs)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`F_NBITS-1:0]    in_data,
  input  logic                   in_last,
  input  logic [nmuxsels-1:0]    in_mux_sel,
  output logic [`F_NBITS-1:0]    v_in [ninputs-1:0],
  output logic [nmuxsels-1:0]    mux_sel,
  output logic                   en,
  input  logic                   layer_ready_pulse,
  output logic                   busy,
  output logic [15:0]            batch_count,
  output logic                   short_batch
);

  localparam int unsigned LAST_IDX = ninputs - 1;

  if (nidxbits != $clog2(ninputs)) begin : g_bad_nidxbits
    $error("computation_layer_loader: nidxbits is derived from ninputs and must not be overridden");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [`F_NBITS-1:0] fill [ninputs-1:0];
  logic [nmuxsels-1:0] fill_mux;
  logic [nidxbits-1:0] widx;
  logic                fill_full;
  logic                fill_pad;

  logic accept_c;
  logic closing_c;
  logic swap_c;
  logic count_c;

  assign in_ready  = ~fill_full & ~rst;
  assign accept_c  = in_valid & in_ready;
  assign closing_c = accept_c & ((widx == nidxbits'(LAST_IDX)) | in_last);
  assign busy      = (state_q == S_BUSY);

  // Layer occupancy: a swap always (re)enters busy; a completion without a swap frees it.
  always_comb begin
    state_d = state_q;
    swap_c  = 1'b0;
    count_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        swap_c = fill_full;
        if (swap_c) state_d = S_BUSY;
      end
      S_BUSY: begin
        count_c = layer_ready_pulse;
        swap_c  = fill_full & layer_ready_pulse;
        if (!swap_c && layer_ready_pulse) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Fill bank, active bank and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx        <= '0;
      fill_full   <= 1'b0;
      fill_pad    <= 1'b0;
      fill_mux    <= '0;
      en          <= 1'b0;
      short_batch <= 1'b0;
      batch_count <= '0;
      mux_sel     <= '0;
      for (int i = 0; i < int'(ninputs); i++) begin
        fill[i] <= '0;
        v_in[i] <= '0;
      end
    end else begin
      en <= swap_c;
      if (count_c) batch_count <= batch_count + 16'd1;

      if (swap_c) begin
        for (int i = 0; i < int'(ninputs); i++) v_in[i] <= fill[i];
        mux_sel     <= fill_mux;
        short_batch <= fill_pad;
        fill_full   <= 1'b0;
      end

      if (accept_c) begin
        fill[widx] <= in_data;
        // A short batch zero-pads every slot above the final element.
        if (in_last) begin
          for (int i = 0; i < int'(ninputs); i++) begin
            if (i > int'(widx)) fill[i] <= '0;
          end
        end
        if (closing_c) begin
          fill_full <= 1'b1;
          fill_pad  <= (widx != nidxbits'(LAST_IDX));
          fill_mux  <= in_mux_sel;
          widx      <= '0;
        end else begin
          widx <= widx + nidxbits'(1);
        end
      end
    end
  end

endmodule

// File: doc/computation_layer_loader.md
Name: computation_layer_loader

Overview:
Upstream feeder for a computation layer. Accepts field elements serially over a valid/ready stream and assembles them into a ninputs-wide input vector. It then launches the layer with a one-cycle en pulse and holds that vector stable until the layer reports completion. Input storage is double-buffered (fill bank + active bank), so the next batch streams in while the current batch computes.

Parameters:
ninputs, 8, number of field elements per batch; drives v_in width of the downstream layer
nmuxsels, 1, width of the mux_sel vector forwarded to the layer
nidxbits, $clog2(ninputs), fill index width; do not override (elaboration error if overridden)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data/in_last/in_mux_sel valid this cycle
in_ready  output  1  loader can accept an element this cycle
in_data  input  `F_NBITS  field element, already reduced mod p
in_last  input  1  final element of a batch; remaining slots zero-filled
in_mux_sel  input  nmuxsels  mux select for this batch; sampled only on the accepted in_last beat or the ninputs-th beat
v_in  output  `F_NBITS x ninputs (unpacked [ninputs-1:0])  active bank to layer
mux_sel  output  nmuxsels  active-bank mux select to layer
en  output  1  one-cycle launch pulse to layer
layer_ready_pulse  input  1  layer completion pulse
busy  output  1  active batch launched and not yet completed
batch_count  output  16  completed batches, wraps at 2^16
short_batch  output  1  last launched batch was zero-padded

Behaviour:
- Accept: in_valid & in_ready at a rising edge. Writes in_data to fill[widx], then widx++.
- in_ready = ~fill_full, combinational from registered state. It is 0 while rst is high.
- fill_full is set on the accept edge when widx == ninputs-1 or in_last = 1.
  - On in_last with widx < ninputs-1, slots widx+1..ninputs-1 are written 0 on the same edge.
  - fill_pad is set if any slots were zero-filled.
  - in_mux_sel is latched into fill_mux on the same edge.
  - widx returns to 0.
- Swap condition at an edge: fill_full & (~busy | layer_ready_pulse). On a swap edge:
  - active <= fill; mux_sel <= fill_mux; short_batch <= fill_pad.
  - fill_full <= 0; busy <= 1; en <= 1.
- en is registered and high for exactly one cycle after each swap edge; otherwise 0.
- busy clears on an edge where layer_ready_pulse = 1 and no swap occurs. batch_count increments on every edge where busy & layer_ready_pulse.
- layer_ready_pulse while ~busy is ignored. It does not count and sets no state.
- Timing:
  - Last element accepted at edge E0 with layer idle: swap at E1, en high during cycle E1–E2. Min latency from last accept to en = 1 cycle.
  - Back-to-back: fill_full already set and layer_ready_pulse arrives at edge E: swap at E and en the next cycle. busy stays 1 and batch_count still increments.
  - Accept and swap on the same edge cannot collide: accept requires ~fill_full and swap requires fill_full.
- v_in and mux_sel change only on swap edges or reset. They are stable for the whole busy period.
- in_last and in_data are ignored when not accepted.
- Reset (any cycle, including mid-fill or while busy): on the rst edge, all of the following are 0:
  - widx, fill_full, fill_pad, busy, en, short_batch, batch_count, mux_sel, all v_in and fill entries.
  - An in-flight batch is discarded. A layer_ready_pulse arriving after reset is ignored per the ~busy rule.
- Arithmetic: no field operations. Data is passed through bit-exact at width `F_NBITS.

Test Plan:
- Reset then ninputs=8 elements 1..8 streamed every cycle, layer idle → in_ready low after 8th accept; en single pulse 1 cycle later; v_in[i]=i+1; busy=1; short_batch=0.
- Batch of 3 elements (10,20,30) with in_last on 3rd → v_in={10,20,30,0,0,0,0,0}; short_batch=1; en 1 cycle after 3rd accept.
- Second full batch loaded while busy; layer_ready_pulse 5 cycles later → in_ready=0 after 8th accept; swap on the pulse edge, en next cycle; busy never drops; batch_count=1; v_in stable before the swap.
- layer_ready_pulse asserted with busy=0 → batch_count stays 0, no state change. in_valid toggling 1/0 every cycle across a batch → exactly 8 accepts, correct element ordering.
- rst asserted mid-fill (after 4 accepts) and again while busy → all outputs 0 after the rst edge; the next 8-element batch loads from index 0 correctly.
- Batch with in_last on the 8th element and in_mux_sel=1 (nmuxsels=1) → short_batch=0; mux_sel=1 appears on the swap edge; earlier beats' in_mux_sel values ignored.
